aes_shiftrows_pipe: RTL and testbench
=====================================

Name: aes_shiftrows_pipe

Overview:
- Parametrised, pipelined ShiftRows/InvShiftRows stage for the AES-256-GCM datapath. Supports Rijndael block widths of Nb = 4, 6 or 8 columns and a per-beat forward/inverse mode.
- Results are registered behind a valid/ready handshake, with 1 or 2 register stages.
- Sits between SubBytes and MixColumns in the round pipeline. The inverse mode serves the decrypt key-check path.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8. Any other value is a elaboration error. DATA_W = 32*NB.
- STAGES, 1, pipeline register stages; legal values 1 or 2. Latency equals STAGES.
- TAG_W, 8, width of sideband tag carried alongside the data, unmodified. Must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  input state
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat
- in_tag  in  TAG_W  sideband, passed through
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  permuted state
- out_tag  out  TAG_W  tag of that beat
- busy  out  1  OR of all stage valid flags

Behaviour:
- Reset is asynchronous and active-low.
- Byte map: state byte index k = r + 4c (row r 0..3, column c 0..NB-1), located at in_data[DATA_W-1-8k -: 8]. Byte 0 is the MSB byte.
- Row shift offsets sh(r):
  - NB = 4 or 6: 0, 1, 2, 3
  - NB = 8: 0, 1, 3, 4
- Forward (inv = 0): out[r,c] = in[r,(c+sh(r)) mod NB].
- Inverse (inv = 1): out[r,c] = in[r,(c−sh(r)+NB) mod NB].
- The permutation is purely combinational on in_data and is applied before stage 1. Stage 2, when present, is a plain register.
- Each stage holds one entry: valid flag, data and tag.
- Stage i loads when its upstream is valid and it is ready. Ready is (!valid_i || ready_of_downstream).
- in_ready = ready of stage 1; out_valid = valid of the last stage.
- Full throughput: one beat per cycle when out_ready is held high.
- Backpressure: when out_ready = 0 and all stages are valid:
  - in_ready = 0
  - data and tag in every stage hold stable
  - out_valid stays 1
- A transfer happens on a cycle with valid & ready at an interface. Any beat presented while in_ready = 0 is not consumed; it is not dropped or duplicated.
- Simultaneous capture and drain in the same cycle on a full stage is legal and loses nothing.
- in_inv is captured per beat. Mixed forward and inverse beats may be back-to-back and each is permuted by its own mode.
- Reset (rst_n = 0), asynchronous and effective at any time, including mid-stream: all valid flags, out_data, out_tag, busy and in_ready are forced to 0. In-flight beats are discarded.
- After rst_n deasserts, in_ready = 1 from the first clock edge onward.
- Data and tag registers also reset to 0.
- No X propagation: out_data is never driven from an uncaptured in_data.

Test Plan:
- NB = 4, STAGES = 1, forward. Input d42711aee0bf98f1b8b45de51e415230, tag 0x5A → one cycle later out_data = d4bf5d30e0b452aeb84111f11e2798e5, out_tag = 0x5A.
- NB = 4, inverse. Input d4bf5d30e0b452aeb84111f11e2798e5 → out_data = d42711aee0bf98f1b8b45de51e415230. Also input 000102…0f forward → 00050a0f04090e03080d0207 0c01060b (concatenated).
- NB = 8, forward. Input bytes 00..1f ascending → first output column 00 05 0e 13. Forward followed by inverse restores the input for NB = 4, 6 and 8 with random data.
- STAGES = 2, stream 16 beats with alternating in_inv. Toggle out_ready randomly, including 5 cycles held low. Required:
  - in_ready drops within the cycle both stages fill
  - no beat lost or duplicated
  - order preserved
  - output data stable while stalled
  - latency 2 when unstalled
- Continuous streaming with out_ready = 1 → one output per cycle, tags ascending 0..N-1 with no gaps.
- Assert rst_n low mid-stream, asynchronously between edges, with both stages full → out_valid and busy drop immediately. After release, the first output is the first beat accepted post-reset.

Source files
------------

// File: rtl/aes_shiftrows_pipe.sv
// ShiftRows / InvShiftRows permutation for Rijndael states of 4, 6 or 8 columns,
// followed by a 1- or 2-deep valid/ready register pipeline carrying a sideband tag.
module aes_shiftrows_pipe #(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAG_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*NB-1:0]    in_data,
   input  logic                in_inv,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*NB-1:0]    out_data,
   output logic [TAG_W-1:0]    out_tag,
   output logic                busy
);

   localparam int DATA_W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
   end
   if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
      $error("aes_shiftrows_pipe: STAGES must be 1 or 2");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("aes_shiftrows_pipe: TAG_W must be at least 1");
   end

   logic [DATA_W-1:0] fwd_data;
   logic [DATA_W-1:0] inv_data;
   logic [DATA_W-1:0] perm_data;

   // Byte k = r + 4c sits at the MSB end; NB = 8 uses the wider row offsets 0,1,3,4.
   for (genvar gi = 0; gi < NB; gi++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
         localparam int SH    = (NB == 8 && gr >= 2) ? gr + 1 : gr;
         localparam int SRC_F = (gi + SH) % NB;
         localparam int SRC_I = (gi - SH + NB) % NB;
         assign fwd_data[DATA_W-1-8*(gr+4*gi) -: 8] = in_data[DATA_W-1-8*(gr+4*SRC_F) -: 8];
         assign inv_data[DATA_W-1-8*(gr+4*gi) -: 8] = in_data[DATA_W-1-8*(gr+4*SRC_I) -: 8];
      end
   end

   assign perm_data = in_inv ? inv_data : fwd_data;

   logic                             init_done_q;
   logic [STAGES-1:0]                valid_q;
   logic [STAGES-1:0][DATA_W-1:0]    data_q;
   logic [STAGES-1:0][TAG_W-1:0]     tag_q;

   logic [STAGES:0]                  ready_c;
   logic [STAGES-1:0]                valid_d;
   logic [STAGES-1:0][DATA_W-1:0]    data_d;
   logic [STAGES-1:0][TAG_W-1:0]     tag_d;

   // Ready ripples back from the output: a stage is free if empty or draining.
   always_comb begin
      ready_c         = '0;
      ready_c[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         ready_c[i] = !valid_q[i] || ready_c[i+1];
      end
   end

   always_comb begin
      valid_d    = '0;
      data_d     = '0;
      tag_d      = '0;
      valid_d[0] = in_valid && init_done_q;
      data_d[0]  = perm_data;
      tag_d[0]   = in_tag;
      for (int i = 1; i < STAGES; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
         tag_d[i]   = tag_q[i-1];
      end
   end

   // Data and tag only move with a real transfer, so nothing uncaptured reaches the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done_q <= 1'b0;
         valid_q     <= '0;
         data_q      <= '0;
         tag_q       <= '0;
      end else begin
         init_done_q <= 1'b1;
         for (int i = 0; i < STAGES; i++) begin
            if (ready_c[i]) begin
               valid_q[i] <= valid_d[i];
               if (valid_d[i]) begin
                  data_q[i] <= data_d[i];
                  tag_q[i]  <= tag_d[i];
               end
            end
         end
      end
   end

   assign in_ready  = init_done_q && ready_c[0];
   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign busy      = |valid_q;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe: directed vectors, random round trips against a byte-level
// reference permutation, a scoreboarded stream with backpressure, and a mid-stream reset.
module tb_aes_shiftrows_pipe;

   logic clk;
   logic rst_n;

   // A: NB=4 STAGES=1, B: NB=8 STAGES=2, C: NB=6 STAGES=1
   logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
   logic [127:0] a_in_data, a_out_data;
   logic [7:0]   a_in_tag, a_out_tag;
   logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
   logic [255:0] b_in_data, b_out_data;
   logic [7:0]   b_in_tag, b_out_tag;
   logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_busy;
   logic [191:0] c_in_data, c_out_data;
   logic [7:0]   c_in_tag, c_out_tag;

   aes_shiftrows_pipe #(.NB(4), .STAGES(1), .TAG_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
      .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_tag(a_out_tag), .busy(a_busy));

   aes_shiftrows_pipe #(.NB(8), .STAGES(2), .TAG_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
      .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy));

   aes_shiftrows_pipe #(.NB(6), .STAGES(1), .TAG_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_inv(c_in_inv),
      .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .out_tag(c_out_tag), .busy(c_busy));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: state right-aligned in 256 bits, byte k = r + 4c counted from the top byte.
   function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
      logic [7:0]   src [32];
      logic [255:0] o;
      int           w;
      int           sh;
      int           sc;
      o = '0;
      w = 32 * nb;
      for (int k = 0; k < 4 * nb; k++) src[k] = d[w-1-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < nb; c++) begin
            sh = (nb == 8 && r >= 2) ? r + 1 : r;
            sc = inv ? (c - sh + nb) % nb : (c + sh) % nb;
            o[w-1-8*(r+4*c) -: 8] = src[r+4*sc];
         end
      end
      return o;
   endfunction

   task automatic a_xfer(input logic [127:0] d, input logic inv, input logic [7:0] tg,
                         output logic [127:0] od, output logic [7:0] ot);
      a_in_data = d; a_in_inv = inv; a_in_tag = tg; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      check_eq("a_out_valid_lat1", a_out_valid, 1);
      od = a_out_data;
      ot = a_out_tag;
   endtask

   task automatic c_xfer(input logic [191:0] d, input logic inv, input logic [7:0] tg,
                         output logic [191:0] od, output logic [7:0] ot);
      c_in_data = d; c_in_inv = inv; c_in_tag = tg; c_in_valid = 1'b1;
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      check_eq("c_out_valid_lat1", c_out_valid, 1);
      od = c_out_data;
      ot = c_out_tag;
   endtask

   task automatic b_xfer(input logic [255:0] d, input logic inv, input logic [7:0] tg,
                         output logic [255:0] od, output logic [7:0] ot);
      b_in_data = d; b_in_inv = inv; b_in_tag = tg; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      check_eq("b_out_valid_after1", b_out_valid, 0);
      @(posedge clk); #1;
      check_eq("b_out_valid_lat2", b_out_valid, 1);
      od = b_out_data;
      ot = b_out_tag;
   endtask

   typedef struct {
      logic [255:0] data;
      logic [7:0]   tag;
      int           cyc;
   } beat_t;

   beat_t sb[$];
   int    acc_total;
   int    del_total;
   bit    mon_done;

   // Streams n beats into B; rand_ready selects random backpressure (with a 5-cycle hold-off)
   // versus out_ready held high, where latency and one-beat-per-cycle are also checked.
   task automatic b_stream(input int n, input bit rand_ready);
      acc_total = 0;
      del_total = 0;
      mon_done  = 1'b0;
      sb.delete();
      fork
         begin : driver
            logic [255:0] d;
            logic         inv;
            bit           acc;
            for (int i = 0; i < n; i++) begin
               d = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
               inv = rand_ready ? ((i % 2) == 1) : 1'($urandom_range(0, 1));
               b_in_data = d; b_in_inv = inv; b_in_tag = 8'(i); b_in_valid = 1'b1;
               acc = 1'b0;
               for (int w = 0; w < 200 && !acc; w++) begin
                  @(negedge clk);
                  acc = b_in_ready;
                  @(posedge clk); #1;
               end
               if (!acc) begin
                  check_eq("b_accept_timeout", 0, 1);
                  break;
               end
               sb.push_back('{data: ref_perm(8, d, inv), tag: 8'(i), cyc: cyc});
               acc_total++;
            end
            b_in_valid = 1'b0;
         end
         begin : monitor
            beat_t        e;
            int           got;
            int           last_cyc;
            int           in_flight;
            bit           stall_prev;
            logic [255:0] held_data;
            logic [7:0]   held_tag;
            got = 0; last_cyc = 0; stall_prev = 1'b0; held_data = '0; held_tag = '0;
            for (int w = 0; w < 2000 && got < n; w++) begin
               @(negedge clk);
               in_flight = acc_total - del_total;
               check_eq("b_in_ready", b_in_ready, (in_flight < 2) || b_out_ready);
               check_eq("b_busy", b_busy, in_flight > 0);
               if (stall_prev) begin
                  check_eq("b_stall_valid", b_out_valid, 1);
                  check_eq("b_stall_data", b_out_data, held_data);
                  check_eq("b_stall_tag", b_out_tag, held_tag);
               end
               stall_prev = b_out_valid && !b_out_ready;
               held_data  = b_out_data;
               held_tag   = b_out_tag;
               if (b_out_valid && b_out_ready) begin
                  if (sb.size() == 0) begin
                     check_eq("b_unexpected_beat", 1, 0);
                  end else begin
                     e = sb.pop_front();
                     check_eq("b_stream_data", b_out_data, e.data);
                     check_eq("b_stream_tag", b_out_tag, 8'(got));
                     if (!rand_ready) begin
                        check_eq("b_latency", cyc - e.cyc + 1, 2);
                        if (got > 0) check_eq("b_back_to_back", cyc, last_cyc + 1);
                     end
                  end
                  last_cyc = cyc;
                  got++;
                  del_total++;
               end
            end
            check_eq("b_drain_count", got, n);
            mon_done = 1'b1;
         end
         begin : ready_drv
            for (int k = 0; k < 3000 && !mon_done; k++) begin
               if (rand_ready) b_out_ready = (k >= 6 && k < 11) ? 1'b0 : 1'($urandom_range(0, 1));
               else            b_out_ready = 1'b1;
               @(posedge clk); #1;
            end
            b_out_ready = 1'b1;
         end
      join
   endtask

   initial begin
      logic [127:0] a_d, a_o, a_z;
      logic [191:0] c_d, c_o, c_z;
      logic [255:0] b_d, b_o, b_z;
      logic [7:0]   t;

      rst_n = 1'b0;
      a_in_valid = 0; a_in_data = '0; a_in_inv = 0; a_in_tag = '0; a_out_ready = 1;
      b_in_valid = 0; b_in_data = '0; b_in_inv = 0; b_in_tag = '0; b_out_ready = 1;
      c_in_valid = 0; c_in_data = '0; c_in_inv = 0; c_in_tag = '0; c_out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_a_out_valid", a_out_valid, 0);
      check_eq("rst_a_in_ready", a_in_ready, 0);
      check_eq("rst_a_busy", a_busy, 0);
      check_eq("rst_a_out_data", a_out_data, 0);
      check_eq("rst_b_in_ready", b_in_ready, 0);
      check_eq("rst_b_out_tag", b_out_tag, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_a_in_ready", a_in_ready, 1);
      check_eq("post_rst_b_in_ready", b_in_ready, 1);
      check_eq("post_rst_c_in_ready", c_in_ready, 1);

      a_xfer(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 8'h5A, a_o, t);
      check_eq("a_kat_fwd", a_o, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      check_eq("a_kat_tag", t, 8'h5A);
      a_xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 8'hA5, a_o, t);
      check_eq("a_kat_inv", a_o, 128'hd42711aee0bf98f1b8b45de51e415230);
      check_eq("a_kat_inv_tag", t, 8'hA5);
      a_xfer(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 8'h01, a_o, t);
      check_eq("a_ramp_fwd", a_o, 128'h00050a0f04090e03080d02070c01060b);
      @(posedge clk); #1;
      check_eq("a_drained", a_busy, 0);

      for (int i = 0; i < 3; i++) begin
         a_d = {$urandom(), $urandom(), $urandom(), $urandom()};
         a_xfer(a_d, 1'b0, 8'(i), a_o, t);
         check_eq("a_rand_fwd", a_o, ref_perm(4, {128'b0, a_d}, 1'b0));
         a_xfer(a_o, 1'b1, 8'(i), a_z, t);
         check_eq("a_roundtrip", a_z, a_d);
         c_d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         c_xfer(c_d, 1'b0, 8'(i), c_o, t);
         check_eq("c_rand_fwd", c_o, ref_perm(6, {64'b0, c_d}, 1'b0));
         c_xfer(c_o, 1'b1, 8'(i), c_z, t);
         check_eq("c_roundtrip", c_z, c_d);
      end

      b_d = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      b_xfer(b_d, 1'b0, 8'h11, b_o, t);
      check_eq("b_ramp_col0", b_o[255:224], 32'h00050e13);
      check_eq("b_ramp_fwd", b_o, ref_perm(8, b_d, 1'b0));
      check_eq("b_ramp_tag", t, 8'h11);
      b_xfer(b_o, 1'b1, 8'h12, b_z, t);
      check_eq("b_ramp_roundtrip", b_z, b_d);
      b_d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      b_xfer(b_d, 1'b0, 8'h13, b_o, t);
      b_xfer(b_o, 1'b1, 8'h14, b_z, t);
      check_eq("b_rand_roundtrip", b_z, b_d);
      repeat (2) @(posedge clk);
      #1;

      b_stream(16, 1'b1);
      b_stream(20, 1'b0);

      // Fill both stages of B under backpressure, then reset between edges.
      b_out_ready = 1'b0;
      b_in_data = 256'h1; b_in_inv = 0; b_in_tag = 8'hE1; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_data = 256'h2; b_in_tag = 8'hE2;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      check_eq("full_b_out_valid", b_out_valid, 1);
      check_eq("full_b_in_ready", b_in_ready, 0);
      check_eq("full_b_busy", b_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_out_valid", b_out_valid, 0);
      check_eq("async_rst_busy", b_busy, 0);
      check_eq("async_rst_in_ready", b_in_ready, 0);
      check_eq("async_rst_out_data", b_out_data, 0);
      check_eq("async_rst_out_tag", b_out_tag, 0);
      #3 rst_n = 1'b1;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("rerst_in_ready", b_in_ready, 1);
      b_d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      b_xfer(b_d, 1'b1, 8'hC3, b_o, t);
      check_eq("rerst_first_data", b_o, ref_perm(8, b_d, 1'b1));
      check_eq("rerst_first_tag", t, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
